tsn_egress_sched: RTL

TSN_EGRESS_SCHED -- requirements
Module: tsn_egress_sched

---
 rtl/tsn_egress_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/tsn_egress_sched.sv
// TSN egress scheduler: per-queue descriptor FIFOs, strict-priority issue gated by the
// time-slot window, and token-bucket policing on a single rate-limited queue.
module tsn_egress_sched #(
   parameter  int unsigned NUM_Q      = 4,
   parameter  int unsigned Q_DEPTH    = 16,
   parameter  int unsigned RATE_Q     = NUM_Q - 1,
   parameter  int unsigned BUCKET_MAX = 16384,
   localparam int unsigned CW         = $clog2(Q_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [23:0]           in_md,
   input  logic                  in_md_wr,
   input  logic                  in_time_slot_flag,
   input  logic [31:0]           in_rate_limit,
   input  logic                  in_egress_ready,
   input  logic                  in_pkt_done,
   output logic [7:0]            out_md,
   output logic                  out_md_wr,
   output logic                  out_bandwidth_discard,
   output logic [NUM_Q*CW-1:0]   out_q_used_cnt,
   output logic [63:0]           out_mdin_cnt,
   output logic [63:0]           out_mdout_cnt,
   output logic [31:0]           out_drop_cnt
);

   localparam int unsigned   AW      = $clog2(Q_DEPTH);
   localparam int unsigned   QW      = $clog2(NUM_Q);
   localparam logic [QW-1:0] LAST_Q  = QW'(NUM_Q - 1);
   localparam logic [QW-1:0] POL_Q   = QW'(RATE_Q);
   localparam logic [20:0]   TOK_MAX = 21'(BUCKET_MAX);

   typedef enum logic {IDLE, WAIT_DONE} state_t;
   state_t state_q;

   // each entry holds {length[11:0], buffer id[7:0]}
   logic [19:0]   mem_q    [NUM_Q][Q_DEPTH];
   logic [AW-1:0] wr_ptr_q [NUM_Q];
   logic [AW-1:0] wr_ptr_d [NUM_Q];
   logic [AW-1:0] rd_ptr_q [NUM_Q];
   logic [AW-1:0] rd_ptr_d [NUM_Q];
   logic [CW-1:0] cnt_q    [NUM_Q];
   logic [CW-1:0] cnt_d    [NUM_Q];
   logic [19:0]   tok_q, tok_d;
   logic [31:0]   rate_q;
   logic [15:0]   per_q, per_d;

   logic [QW-1:0] enq_sel, pop_sel;
   logic          enq_full, enq_ok, enq_drop;
   logic          pop_found, issue, policed, discard, consume;
   logic          rate_chg, refill;
   logic [19:0]   head;
   logic [20:0]   tok_sum;

   always_comb begin : enq_path
      enq_sel  = (in_md[11:8] >= 4'(NUM_Q)) ? LAST_Q : QW'(in_md[11:8]);
      enq_full = (cnt_q[enq_sel] == CW'(Q_DEPTH));
      enq_ok   = in_md_wr && !enq_full;
      enq_drop = in_md_wr && enq_full;
   end

   always_comb begin : issue_path
      pop_found = 1'b0;
      pop_sel   = '0;
      for (int unsigned i = 0; i < NUM_Q; i++) begin
         if (!pop_found && (cnt_q[i] != '0) && (!in_time_slot_flag || (i == 0))) begin
            pop_found = 1'b1;
            pop_sel   = QW'(i);
         end
      end
      issue   = (state_q == IDLE) && in_egress_ready && pop_found;
      head    = mem_q[pop_sel][rd_ptr_q[pop_sel]];
      policed = issue && (pop_sel == POL_Q) && (in_rate_limit != '0);
      discard = policed && ({8'd0, head[19:8]} > tok_q);
      consume = policed && !discard;
   end

   // consume is judged against pre-refill tokens; the refill lands in the same sum
   always_comb begin : bucket_path
      rate_chg = (in_rate_limit != rate_q);
      refill   = !rate_chg && (per_q == in_rate_limit[31:16]);
      per_d    = (rate_chg || refill) ? '0 : per_q + 16'd1;
      tok_sum  = {1'b0, tok_q}
               - (consume ? {9'd0, head[19:8]} : 21'd0)
               + (refill ? {5'd0, in_rate_limit[15:0]} : 21'd0);
      tok_d    = (tok_sum > TOK_MAX) ? TOK_MAX[19:0] : tok_sum[19:0];
   end

   always_comb begin : queue_path
      out_q_used_cnt = '0;
      for (int unsigned i = 0; i < NUM_Q; i++) begin
         cnt_d[i]    = cnt_q[i];
         wr_ptr_d[i] = wr_ptr_q[i];
         rd_ptr_d[i] = rd_ptr_q[i];
         if (enq_ok && (enq_sel == QW'(i))) begin
            cnt_d[i]    = cnt_d[i] + CW'(1);
            wr_ptr_d[i] = wr_ptr_q[i] + AW'(1);
         end
         if (issue && (pop_sel == QW'(i))) begin
            cnt_d[i]    = cnt_d[i] - CW'(1);
            rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
         end
         out_q_used_cnt[i*CW +: CW] = cnt_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (enq_ok) mem_q[enq_sel][wr_ptr_q[enq_sel]] <= {in_md[23:12], in_md[7:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q               <= IDLE;
         out_md                <= '0;
         out_md_wr             <= 1'b0;
         out_bandwidth_discard <= 1'b0;
         out_mdin_cnt          <= '0;
         out_mdout_cnt         <= '0;
         out_drop_cnt          <= '0;
         tok_q                 <= TOK_MAX[19:0];
         rate_q                <= '0;
         per_q                 <= '0;
         for (int unsigned i = 0; i < NUM_Q; i++) begin
            cnt_q[i]    <= '0;
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
         end
      end else begin
         out_md_wr <= issue;
         if (issue) begin
            out_md                <= head[7:0];
            out_bandwidth_discard <= discard;
         end
         case (state_q)
            IDLE:      if (issue && !discard) state_q <= WAIT_DONE;
            WAIT_DONE: if (in_pkt_done) state_q <= IDLE;
            default:   state_q <= IDLE;
         endcase
         if (enq_ok) out_mdin_cnt <= out_mdin_cnt + 64'd1;
         if (issue) out_mdout_cnt <= out_mdout_cnt + 64'd1;
         if (enq_drop && (out_drop_cnt != '1)) out_drop_cnt <= out_drop_cnt + 32'd1;
         tok_q  <= tok_d;
         rate_q <= in_rate_limit;
         per_q  <= per_d;
         for (int unsigned i = 0; i < NUM_Q; i++) begin
            cnt_q[i]    <= cnt_d[i];
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
         end
      end
   end

endmodule
